// File: rtl/bamse_porta_in.sv
// bamse_porta_in: PacoBlaze input port. Synchronises an 8-bit pin bus, latches
// per-bit selectable edges and raises irq for enabled pending edges.
// Register map (offset from PORT_BASE): +0 DATA (RO), +1 EDGE (W1C),
// +2 MASK (RW), +3 POL (RW, 1 = falling edge).
// Build macro PORTA_IN_DEBOUNCE_EN adds a per-bit stable-cycle debounce
// in front of the level/edge logic.
module bamse_porta_in #(
    parameter logic [7:0]  PORT_BASE       = 8'h10,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pins,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       irq
);

    typedef enum logic [1:0] {
        OFS_DATA = 2'd0,
        OFS_EDGE = 2'd1,
        OFS_MASK = 2'd2,
        OFS_POL  = 2'd3
    } ofs_e;

    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] lvl;
    logic [7:0] lvl_q;
    logic [7:0] edge_flags;
    logic [7:0] mask;
    logic [7:0] pol;
    logic [7:0] det;
    logic [7:0] clr;
    logic [7:0] rd_data;
    logic       hit;
    ofs_e       ofs;

    // Reads have no side effects, so the read strobe carries no information here.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    assign hit = (port_id[7:2] == PORT_BASE[7:2]);
    assign ofs = ofs_e'(port_id[1:0]);

    // Two-flop synchroniser for the asynchronous pins.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
        end
    end

`ifdef PORTA_IN_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] db_cnt [8];

    // Per-bit debounce: adopt s2 only after it has differed from L for DEBOUNCE_CYCLES clocks.
    // NOTE: these counters are ordinary flops, not a RAM, so they take the async reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    assign lvl = s2;
`endif

    // Edge select: rising where POL=0, falling where POL=1; only L transitions count,
    // so rewriting POL can never fabricate an edge.
    assign det = (lvl & ~lvl_q & ~pol) | (~lvl & lvl_q & pol);

    // Write-one-to-clear mask for EDGE, active only on a write to offset +1.
    assign clr = (write_strobe && hit && (ofs == OFS_EDGE)) ? out_port : 8'h00;

    // Previous level, edge flags, interrupt and the RW control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= '0;
            edge_flags <= '0;
            mask       <= '0;
            pol        <= '0;
            irq        <= 1'b0;
        end else begin
            lvl_q      <= lvl;
            // A new edge in the same cycle as its W1C wins, so no event is lost.
            edge_flags <= (edge_flags & ~clr) | det;
            irq        <= |(edge_flags & mask);
            if (write_strobe && hit && (ofs == OFS_MASK)) begin
                mask <= out_port;
            end
            if (write_strobe && hit && (ofs == OFS_POL)) begin
                pol <= out_port;
            end
        end
    end

    // Read mux; returns zero when not addressed so the SoC can OR-merge ports.
    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (ofs)
                OFS_DATA: rd_data = lvl;
                OFS_EDGE: rd_data = edge_flags;
                OFS_MASK: rd_data = mask;
                OFS_POL:  rd_data = pol;
                default:  rd_data = 8'h00;
            endcase
        end
    end

    // Registered read data, one clock behind port_id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_port <= '0;
        end else begin
            in_port <= rd_data;
        end
    end

endmodule
